// File: rtl/immencode_pkg.sv
// -----------------------------------------------------------------------------
// immencode_pkg
//   Shared definitions for the immediate encoder:
//   - immsrc format codes (I/S/B/J)
//   - per-format masks of the instruction bits that hold the immediate
//   - the stage-1 payload struct {base, imm, immsrc}
//   - extend_imm(): the extend-unit field rules, used by the optional
//     round-trip self check in the top level
// -----------------------------------------------------------------------------
package immencode_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  // Instruction bits that carry the immediate for each format.
  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] imm;
    logic [1:0]  immsrc;
  } stage_pay_t;

  // Rebuild the sign-extended immediate from an encoded instruction word.
  function automatic logic [31:0] extend_imm(input logic [31:0] instr,
                                             input logic [1:0]  immsrc);
    logic [31:0] ext;
    ext = '0;
    case (immsrc)
      IMM_I: ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_J: ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: ext = '0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/immencode_unit_pack.sv
// -----------------------------------------------------------------------------
// immfield_pack
//   Combinational packer: clears the immediate field of base_i for the chosen
//   format, ORs in the immediate bits, and flags immediates that do not fit.
//   When the immediate does not fit, the truncated bits are still packed.
//
//   Ports:
//     base_i    [31:0]  instruction word (immediate-field bits ignored)
//     imm_i     [31:0]  sign-extended immediate
//     immsrc_i  [1:0]   format: 00 I, 01 S, 10 B, 11 J
//     instr_o   [31:0]  encoded instruction
//     err_o             immediate not representable in the format
// -----------------------------------------------------------------------------
module immfield_pack
  import immencode_pkg::*;
(
  input  logic [31:0] base_i,
  input  logic [31:0] imm_i,
  input  logic [1:0]  immsrc_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [31:0] field;
  logic [31:0] mask;

  always_comb begin
    field = '0;
    mask  = MASK_I;
    err_o = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        mask  = MASK_I;
        field = {imm_i[11:0], 20'b0};
        // Upper bits must all be copies of the sign bit imm[11].
        err_o = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      IMM_S: begin
        mask  = MASK_S;
        field = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        err_o = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      IMM_B: begin
        mask  = MASK_B;
        field = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        err_o = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
      end
      IMM_J: begin
        mask  = MASK_J;
        field = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        err_o = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
      end
      default: begin
        mask  = MASK_I;
        field = '0;
        err_o = 1'b0;
      end
    endcase
    instr_o = (base_i & ~mask) | field;
  end

endmodule

// File: rtl/immencode_unit.sv
// -----------------------------------------------------------------------------
// immencode_unit
//   Two-stage valid/ready immediate encoder (inverse of the extend unit).
//   Stage 1 registers the input beat; stage 2 registers the packed word and
//   its error flag. Saturating counters track delivered and errored beats.
//
//   Optional build macro: IMMENCODE_ROUNDTRIP_EN adds output rt_mismatch, a
//   sticky flag set when a packed word does not re-extend to its immediate.
//
//   Ports:
//     clk                    rising-edge clock
//     reset                  asynchronous active-low reset
//     in_valid / in_ready    input handshake
//     in_base  [31:0]        base instruction word
//     in_imm   [31:0]        sign-extended immediate
//     in_immsrc[1:0]         format: 00 I, 01 S, 10 B, 11 J
//     out_valid / out_ready  output handshake
//     out_instr[31:0]        encoded instruction
//     out_err                immediate not representable
//     enc_count[CNT_W-1:0]   delivered beats (saturating)
//     err_count[CNT_W-1:0]   delivered beats with out_err=1 (saturating)
//     rt_mismatch            (IMMENCODE_ROUNDTRIP_EN only) sticky check flag
// -----------------------------------------------------------------------------
module immencode_unit
  import immencode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  input  logic [1:0]       in_immsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
`ifdef IMMENCODE_ROUNDTRIP_EN
  ,
  output logic             rt_mismatch
`endif
);

  logic             s1_valid_q, s1_valid_d;
  stage_pay_t       s1_pay_q,   s1_pay_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic             s2_err_q,   s2_err_d;
  logic [CNT_W-1:0] enc_q,      enc_d;
  logic [CNT_W-1:0] errc_q,     errc_d;

  logic        s1_ready, s2_ready;
  logic        in_fire, s1_fire, out_fire;
  logic [31:0] pack_instr;
  logic        pack_err;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_fire  = in_valid && s1_ready;
  assign s1_fire  = s1_valid_q && s2_ready;
  assign out_fire = s2_valid_q && out_ready;

  immfield_pack u_pack (
    .base_i   (s1_pay_q.base),
    .imm_i    (s1_pay_q.imm),
    .immsrc_i (s1_pay_q.immsrc),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pay_d   = s1_pay_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    enc_d      = enc_q;
    errc_d     = errc_q;

    if (s1_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_pay_d.base   = in_base;
      s1_pay_d.imm    = in_imm;
      s1_pay_d.immsrc = in_immsrc;
    end

    // Stage 2 only reloads when its current beat leaves, so the output
    // holds steady under backpressure.
    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s1_fire) begin
      s2_instr_d = pack_instr;
      s2_err_d   = pack_err;
    end

    if (out_fire) begin
      if (!(&enc_q)) enc_d = enc_q + CNT_W'(1);
      if (s2_err_q && !(&errc_q)) errc_d = errc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_pay_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      enc_q      <= '0;
      errc_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pay_q   <= s1_pay_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      enc_q      <= enc_d;
      errc_q     <= errc_d;
    end
  end

`ifdef IMMENCODE_ROUNDTRIP_EN
  // The re-extension is evaluated on the word being loaded into stage 2,
  // against the immediate registered alongside it in stage 1.
  logic rt_q, rt_d;

  always_comb begin
    rt_d = rt_q;
    if (s1_fire && !pack_err &&
        (extend_imm(pack_instr, s1_pay_q.immsrc) != s1_pay_q.imm))
      rt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rt_q <= 1'b0;
    else        rt_q <= rt_d;
  end

  assign rt_mismatch = rt_q && !s2_err_q;
`endif

  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign enc_count = enc_q;
  assign err_count = errc_q;

endmodule

// File: doc/immencode_unit.md
Name: immencode_unit

Overview:
- Inverse of the extend unit. Takes a base instruction word with its immediate fields zero, plus a 32-bit sign-extended immediate and an immsrc format.
- Packs the immediate into the RISC-V I/S/B/J field positions and flags any immediate the format cannot represent.
- Two-stage valid/ready pipeline used by the program loader/assembler path ahead of instruction memory. Also keeps saturating statistics counters.

Parameters:
- CNT_W, 16, width of the encoded-count and error-count counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept an input beat
- in_base  in  32  instruction word; bits in the immediate positions are ignored
- in_imm  in  32  sign-extended immediate
- in_immsrc  in  2  format: 00 I, 01 S, 10 B, 11 J
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate not representable in the selected format
- enc_count  out  CNT_W  number of beats delivered
- err_count  out  CNT_W  number of beats delivered with out_err=1

Behaviour:
- Reset (asynchronous assert, synchronous release): both stage valids=0, out_valid=0, out_instr=0, out_err=0, counters=0. in_ready=1 after reset releases.
- Reset mid-operation discards all in-flight beats; nothing is replayed.
- Stage 1 registers the input beat. Stage 2 registers the packed result and err.
- Latency: an input accepted in cycle N is presented at the output in cycle N+2 if there is no backpressure.
- Handshake: a beat transfers when valid && ready.
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready.
- Throughput: one beat per cycle. Order is preserved. out_instr and out_err stay stable while out_valid && !out_ready.
- Field masking: the immediate field bits of in_base are cleared, then the packed immediate bits are ORed in. All other base bits pass through unchanged.
- Field packing:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Error rules:
  - I/S: err=1 unless imm[31:11] is all-equal.
  - B: err=1 unless imm[31:12] is all-equal and imm[0]=0.
  - J: err=1 unless imm[31:20] is all-equal and imm[0]=0.
  - When err=1 the output is still packed with the truncated bits.
- Counters: enc_count increments on each output transfer. err_count increments on each output transfer with out_err=1. Both saturate at all-ones with no wrap.

Optional Feature:
- Macro: IMMENCODE_ROUNDTRIP_EN.
- When defined, stage 2 re-extends the packed word using the extend-unit field rules and compares the result with the registered imm.
- A mismatch with err=0 sets sticky output rt_mismatch (1 bit, cleared only by reset). rt_mismatch is held 0 whenever err=1.
- When not defined, the port and logic are absent.

Decomposition:
- Package immencode_pkg: immsrc codes IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11; per-format field-mask constants; the stage payload struct {base, imm, immsrc}.
- Sub-module immfield_pack (combinational): inputs base, imm, immsrc; outputs instr, err. It is instantiated in stage 2.

Test Plan:
- I format: base=0x0004A303, imm=0xFFFFFFFC, src=00 -> out_instr=0xFFC4A303, err=0, appears 2 cycles after acceptance.
- S format: base=0x0064A023, imm=0xFFFFFFFC, src=01 -> 0xFE64AE23, err=0. B format: base=0x00000063, imm=0xFFFFFFFC, src=10 -> 0xFE000EE3, err=0.
- Errors: I with imm=0x00000800 -> err=1, out_instr=0x8004A303, err_count=1. B with imm=0x00000005 -> err=1.
- Backpressure: hold out_ready=0 and offer 3 beats. Exactly 2 are accepted, then in_ready=0 and out_instr is stable. Raise out_ready -> all 3 beats emerge in order at 1 per cycle; enc_count=3.
- Reset mid-stream: assert reset while both stages are valid -> out_valid=0 immediately, counters=0, no stale beat after release.
- Saturation: with CNT_W=4, push 20 beats -> enc_count stays 0xF.
